// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch time counter.
//   DIGIT_W          width of one BCD digit
//   LIMIT_9/LIMIT_5  highest value of decimal / sexagesimal-tens digits
//   *_LSB            bit offsets of each digit inside time_bcd_out
//   max_time_bcd()   builds the MM:59.99 saturation pattern for a minute limit
package stopwatch_pkg;

  localparam int DIGIT_W = 4;
  localparam int TIME_W  = 6 * DIGIT_W;

  localparam int LIMIT_9 = 9;
  localparam int LIMIT_5 = 5;

  localparam int CS_ONES_LSB  = 0;
  localparam int CS_TENS_LSB  = 4;
  localparam int SEC_ONES_LSB = 8;
  localparam int SEC_TENS_LSB = 12;
  localparam int MIN_ONES_LSB = 16;
  localparam int MIN_TENS_LSB = 20;

  function automatic logic [TIME_W-1:0] max_time_bcd(input int max_min);
    logic [TIME_W-1:0] t;
    t = '0;
    t[MIN_TENS_LSB +: DIGIT_W] = DIGIT_W'(max_min / 10);
    t[MIN_ONES_LSB +: DIGIT_W] = DIGIT_W'(max_min % 10);
    t[SEC_TENS_LSB +: DIGIT_W] = DIGIT_W'(LIMIT_5);
    t[SEC_ONES_LSB +: DIGIT_W] = DIGIT_W'(LIMIT_9);
    t[CS_TENS_LSB  +: DIGIT_W] = DIGIT_W'(LIMIT_9);
    t[CS_ONES_LSB  +: DIGIT_W] = DIGIT_W'(LIMIT_9);
    return t;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit counting 0..LIMIT and wrapping to 0.
//   clk, reset  clock and asynchronous active-high reset
//   en          advance the digit by one this edge
//   clr         synchronous clear, wins over en
//   digit       current digit value
//   carry       high when this digit is about to wrap (en and digit==LIMIT);
//               drives the next digit's en so a whole chain rolls in one edge
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter int LIMIT = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               clr,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry
);

  logic at_limit;

  assign at_limit = (digit == DIGIT_W'(LIMIT));
  assign carry    = en && at_limit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else if (en) begin
      digit <= at_limit ? '0 : digit + DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/stopwatch_time_counter.sv
// Stopwatch counting MM:SS.cc in BCD, saturating at MAX_MIN:59.99.
//   clk                   system clock
//   reset                 asynchronous active-high reset
//   timer_run_en_in       count while high (pause keeps prescaler phase)
//   timer_reset_cmd_in    synchronous clear of count and prescaler
//   time_bcd_out          {min_tens,min_ones,sec_tens,sec_ones,cs_tens,cs_ones}
//   tick_pulse_out        one-cycle pulse coincident with each count update
//   max_time_reached_out  high while the count equals MAX_MIN:59.99
module stopwatch_time_counter
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TICK_HZ     = 100,
  parameter int MAX_MIN     = 59
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              timer_run_en_in,
  input  logic              timer_reset_cmd_in,
  output logic [TIME_W-1:0] time_bcd_out,
  output logic              tick_pulse_out,
  output logic              max_time_reached_out
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TIME_W-1:0] MAX_TIME = max_time_bcd(MAX_MIN);

  if (DIV < 2) begin : g_bad_div
    $fatal(1, "stopwatch_time_counter: CLK_FREQ_HZ/TICK_HZ must be at least 2");
  end
  if (MAX_MIN < 0 || MAX_MIN > 59) begin : g_bad_max
    $fatal(1, "stopwatch_time_counter: MAX_MIN must be within 0..59");
  end

  logic [PW-1:0] presc;
  logic          count_en;
  logic          wrap;
  logic [5:0]    digit_en;
  logic [5:0]    digit_carry;
  logic          unused_top_carry;

  // Counting stops at max; a clear request freezes the prescaler for its edge
  // and then zeroes it, so a coincident wrap never produces an increment.
  assign count_en = timer_run_en_in && !timer_reset_cmd_in && !max_time_reached_out;
  assign wrap     = count_en && (presc == PW'(DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (timer_reset_cmd_in) begin
      presc <= '0;
    end else if (count_en) begin
      presc <= wrap ? '0 : presc + PW'(1);
    end
  end

  // Registered so the pulse is high in exactly the cycle the new count shows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_pulse_out <= 1'b0;
    end else begin
      tick_pulse_out <= wrap;
    end
  end

  // Ripple-enable chain: every digit sees its enable in the same edge, so the
  // full value (e.g. 00:59.99 -> 01:00.00) updates atomically.
  assign digit_en         = {digit_carry[4:0], wrap};
  assign unused_top_carry = digit_carry[5];

  for (genvar i = 0; i < 6; i++) begin : g_digit
    localparam int LIM = (i == 3 || i == 5) ? LIMIT_5 : LIMIT_9;
    bcd_digit_counter #(
      .LIMIT (LIM)
    ) u_digit (
      .clk   (clk),
      .reset (reset),
      .en    (digit_en[i]),
      .clr   (timer_reset_cmd_in),
      .digit (time_bcd_out[i*DIGIT_W +: DIGIT_W]),
      .carry (digit_carry[i])
    );
  end

  assign max_time_reached_out = (time_bcd_out == MAX_TIME);

endmodule

// File: tb/tb_stopwatch_time_counter.sv
module tb_stopwatch_time_counter;

  localparam int CLK_HZ   = 1000;
  localparam int TICK     = 100;
  localparam int DIV      = CLK_HZ / TICK;
  localparam int MAIN_MAX = 59 * 6000 + 5999;
  localparam int SAT_MAX  = 0 * 6000 + 5999;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  logic run_en;
  logic reset_cmd;

  always #5 clk = ~clk;

  logic [23:0] time_main, time_sat;
  logic        tick_main, tick_sat;
  logic        max_main, max_sat;

  stopwatch_time_counter #(
    .CLK_FREQ_HZ (CLK_HZ),
    .TICK_HZ     (TICK),
    .MAX_MIN     (59)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .timer_run_en_in      (run_en),
    .timer_reset_cmd_in   (reset_cmd),
    .time_bcd_out         (time_main),
    .tick_pulse_out       (tick_main),
    .max_time_reached_out (max_main)
  );

  stopwatch_time_counter #(
    .CLK_FREQ_HZ (CLK_HZ),
    .TICK_HZ     (TICK),
    .MAX_MIN     (0)
  ) dut_sat (
    .clk                  (clk),
    .reset                (reset),
    .timer_run_en_in      (run_en),
    .timer_reset_cmd_in   (reset_cmd),
    .time_bcd_out         (time_sat),
    .tick_pulse_out       (tick_sat),
    .max_time_reached_out (max_sat)
  );

  // scoreboard state
  logic [23:0] exp_q[$];
  logic [23:0] exp_sat_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int m_tot = 0, m_ph = 0, s_tot = 0, s_ph = 0;
  int m_ticks_exp = 0, s_ticks_exp = 0, m_ticks_seen = 0, s_ticks_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: elapsed centiseconds as an integer
  function automatic logic [23:0] to_bcd(input int cs);
    int mm, ss, cc;
    mm = cs / 6000;
    ss = (cs / 100) % 60;
    cc = cs % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  task automatic model_edge(input logic run, input logic cmd);
    if (cmd) begin
      m_tot = 0; m_ph = 0; s_tot = 0; s_ph = 0;
    end else if (run) begin
      if (m_tot < MAIN_MAX) begin
        if (m_ph == DIV - 1) begin
          m_ph = 0; m_tot++; m_ticks_exp++;
          exp_q.push_back(to_bcd(m_tot));
        end else m_ph++;
      end
      if (s_tot < SAT_MAX) begin
        if (s_ph == DIV - 1) begin
          s_ph = 0; s_tot++; s_ticks_exp++;
          exp_sat_q.push_back(to_bcd(s_tot));
        end else s_ph++;
      end
    end
  endtask

  // driver: called at negedge+1, returns at the next negedge+1
  task automatic step(input logic run, input logic cmd);
    run_en    = run;
    reset_cmd = cmd;
    @(posedge clk);
    model_edge(run, cmd);
    @(negedge clk);
    #1;
  endtask

  task automatic checkpoint(input string tag);
    check({tag, "_time"}, {8'h0, time_main}, {8'h0, to_bcd(m_tot)});
    check({tag, "_time_sat"}, {8'h0, time_sat}, {8'h0, to_bcd(s_tot)});
    check({tag, "_max"}, {31'h0, max_main}, {31'h0, m_tot == MAIN_MAX});
    check({tag, "_max_sat"}, {31'h0, max_sat}, {31'h0, s_tot == SAT_MAX});
    check({tag, "_ticks"}, m_ticks_seen, m_ticks_exp);
    check({tag, "_ticks_sat"}, s_ticks_seen, s_ticks_exp);
  endtask

  // monitor: pops one expected value per observed tick pulse
  always @(negedge clk) begin
    if (!reset) begin
      if (tick_main) begin
        m_ticks_seen++;
        if (exp_q.size() == 0) check("spurious_tick", {8'h0, time_main}, 32'hFFFF_FFFF);
        else check("tick_value", {8'h0, time_main}, {8'h0, exp_q.pop_front()});
      end
      if (tick_sat) begin
        s_ticks_seen++;
        if (exp_sat_q.size() == 0) check("spurious_tick_sat", {8'h0, time_sat}, 32'hFFFF_FFFF);
        else check("tick_value_sat", {8'h0, time_sat}, {8'h0, exp_sat_q.pop_front()});
      end
    end
  end

  initial begin
    int guard;
    reset = 1'b1; run_en = 1'b0; reset_cmd = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_time", {8'h0, time_main}, 32'h0);
    check("reset_tick", {31'h0, tick_main}, 32'h0);
    check("reset_max", {31'h0, max_main}, 32'h0);
    check("reset_time_sat", {8'h0, time_sat}, 32'h0);
    reset = 1'b0;

    // 30 enabled cycles from cleared -> 3 ticks
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0);
    check("run30_value", {8'h0, time_main}, 32'h0000_0003);
    checkpoint("run30");

    // pause keeps phase: 4 on, 20 off, 5 on -> still 0, one more -> 1
    step(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check("pause_before", {8'h0, time_main}, 32'h0);
    step(1'b1, 1'b0);
    check("pause_after", {8'h0, time_main}, 32'h0000_0001);
    checkpoint("pause");

    // clear coincident with a prescaler wrap
    guard = 0;
    while (m_ph != DIV - 1 && guard < 2 * DIV) begin
      step(1'b1, 1'b0);
      guard++;
    end
    step(1'b1, 1'b1);
    checkpoint("clr_wrap");
    for (int i = 0; i < DIV - 1; i++) step(1'b1, 1'b0);
    check("clr_wrap_phase0", {8'h0, time_main}, 32'h0);
    step(1'b1, 1'b0);
    check("clr_wrap_phase1", {8'h0, time_main}, 32'h0000_0001);

    // randomized run/clear mix
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) < 85, $urandom_range(0, 199) == 0);
      if (i % 50 == 49) checkpoint("rand");
    end

    // async reset between edges mid-count
    step(1'b0, 1'b1);
    for (int i = 0; i < 37; i++) step(1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("async_time", {8'h0, time_main}, 32'h0);
    check("async_tick", {31'h0, tick_main}, 32'h0);
    check("async_max", {31'h0, max_main}, 32'h0);
    check("async_time_sat", {8'h0, time_sat}, 32'h0);
    m_tot = 0; m_ph = 0; s_tot = 0; s_ph = 0;
    @(negedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < DIV; i++) step(1'b1, 1'b0);
    checkpoint("after_async");

    // long run to 00:59.99, rollover of main, saturation of MAX_MIN=0
    step(1'b0, 1'b1);
    guard = 0;
    while (m_tot < 5999 && guard < 70000) begin
      step(1'b1, 1'b0);
      guard++;
    end
    check("reach_5999", {8'h0, time_main}, 32'h0000_5999);
    check("sat_flag", {31'h0, max_sat}, 32'h1);
    checkpoint("at_5999");
    guard = 0;
    while (m_tot < 6000 && guard < 2 * DIV) begin
      step(1'b1, 1'b0);
      guard++;
    end
    check("rollover", {8'h0, time_main}, 32'h0001_0000);
    for (int i = 0; i < 50; i++) step(1'b1, 1'b0);
    check("sat_frozen", {8'h0, time_sat}, 32'h0000_5999);
    checkpoint("sat_hold");
    step(1'b0, 1'b1);
    check("sat_clear", {8'h0, time_sat}, 32'h0);
    check("sat_clear_flag", {31'h0, max_sat}, 32'h0);
    checkpoint("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
